// File: rtl/count_ctrl_pkg.sv
// Package: count_ctrl_pkg
// Shared state encoding and default parameter values for count_enable_gen and
// its button front end (btn_debounce).
package count_ctrl_pkg;

  // FSM state encoding (plain constants so the encoding stays fixed and visible)
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'b00;
  localparam state_t STEP = 2'b01;
  localparam state_t RUN  = 2'b10;

  localparam int unsigned DIV_DEFAULT = 4;
  localparam int unsigned DEB_DEFAULT = 8;

endpackage

// File: rtl/btn_debounce.sv
// Module: btn_debounce
// Push-button front end: two-flop synchroniser, optional debounce filter and
// rising-edge detector. Emits one registered pulse per accepted press.
//
// Build option: define COUNT_DEBOUNCE_EN to compile in the debounce filter.
// Without it the synchronised level is used directly and DEB_CYCLES is unused.
//
// Parameters:
//   DEB_CYCLES  consecutive differing samples needed to accept a level change (1..255)
// Ports:
//   clk          system clock, rising edge
//   Reset        asynchronous active-low reset
//   btn_in       raw button, active-high, asynchronous to clk
//   press_pulse  one-cycle pulse per accepted press (releases produce nothing)
module btn_debounce
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_DEFAULT
) (
  input  logic clk,
  input  logic Reset,
  input  logic btn_in,
  output logic press_pulse
);

  if (DEB_CYCLES == 0 || DEB_CYCLES > 255) begin : g_bad_deb_cycles
    $error("btn_debounce: DEB_CYCLES must be in 1..255");
  end

  logic sync1_q, sync2_q;
  logic deb_level;
  logic deb_prev_q, press_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef COUNT_DEBOUNCE_EN
  localparam logic [7:0] DebTarget = 8'(DEB_CYCLES);

  logic       deb_q, deb_d;
  logic [7:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input disagrees with the
  // accepted level; any agreeing cycle restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q + 8'd1 == DebTarget) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_level = deb_q;
`else
  assign deb_level = sync2_q;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      deb_prev_q <= deb_level;
      press_q    <= deb_level & ~deb_prev_q;
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/count_enable_gen.sv
// Module: count_enable_gen
// Turns push-button presses into the Enable strobe for the downstream counter.
// Step mode issues one Enable per press; run mode toggles a free-running Enable
// every DIV cycles on and off with successive presses.
//
// Build option: COUNT_DEBOUNCE_EN compiles the debounce filter into btn_debounce.
//
// Parameters:
//   DIV         run-mode tick period in cycles (2..16)
//   DEB_CYCLES  debounce stability count (1..255), unused without COUNT_DEBOUNCE_EN
// Ports:
//   clk          system clock, rising edge
//   Reset        asynchronous active-low reset
//   btn_in       raw push button, active-high
//   mode         0 = step, 1 = run; sampled only on a press accepted in IDLE
//   Enable       registered strobe to the counter
//   running      high while in RUN
//   press_pulse  one-cycle pulse per accepted press
module count_enable_gen
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DIV        = DIV_DEFAULT,
  parameter int unsigned DEB_CYCLES = DEB_DEFAULT
) (
  input  logic clk,
  input  logic Reset,
  input  logic btn_in,
  input  logic mode,
  output logic Enable,
  output logic running,
  output logic press_pulse
);

  if (DIV < 2 || DIV > 16) begin : g_bad_div
    $error("count_enable_gen: DIV must be in 2..16");
  end

  localparam logic [3:0] DivLast = 4'(DIV - 1);

  logic       press;
  state_t     state_q, state_d;
  logic [3:0] presc_q, presc_d;
  logic       enable_q, enable_d;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk         (clk),
    .Reset       (Reset),
    .btn_in      (btn_in),
    .press_pulse (press)
  );

  // Prescaler is only meaningful in RUN; it is held at 0 elsewhere so that
  // entering RUN always starts a fresh DIV-cycle period.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    enable_d = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (press) begin
          if (mode) begin
            state_d = RUN;
          end else begin
            state_d  = STEP;
            enable_d = 1'b1;
          end
        end
      end
      STEP: begin
        state_d = IDLE;
        presc_d = '0;
      end
      RUN: begin
        if (press) begin
          // A stop press beats a coincident tick
          state_d = IDLE;
          presc_d = '0;
        end else begin
          enable_d = (presc_q == DivLast);
          presc_d  = (presc_q == DivLast) ? 4'd0 : presc_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      enable_q <= enable_d;
    end
  end

  assign Enable      = enable_q;
  assign running     = (state_q == RUN);
  assign press_pulse = press;

endmodule

// File: tb/tb_count_enable_gen.sv
// Testbench for count_enable_gen: directed button scenarios followed by random
// button/mode activity, compared cycle by cycle with a reference model built
// from sample-history windows and tick arithmetic.
module tb_count_enable_gen;

  localparam int unsigned Div       = 4;
  localparam int unsigned DebCycles = 8;
`ifdef COUNT_DEBOUNCE_EN
  localparam int N = DebCycles;
`else
  localparam int N = 0;
`endif
  localparam int MaxE = 8192;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic btn_in = 1'b0;
  logic mode = 1'b0;
  logic Enable, running, press_pulse;

  count_enable_gen #(
    .DIV        (Div),
    .DEB_CYCLES (DebCycles)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .btn_in      (btn_in),
    .mode        (mode),
    .Enable      (Enable),
    .running     (running),
    .press_pulse (press_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per-edge history since the last reset
  typedef enum {MIdle, MStep, MRun} mstate_e;
  bit      bs [MaxE];  // btn_in sampled at edge k
  bit      dl [MaxE];  // accepted level after edge k
  bit      pr [MaxE];  // press_pulse after edge k
  int      e;
  int      last_flip;
  int      run_start;
  bit      mode_s;
  bit      exp_en;
  mstate_e st;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (edge %0d, t=%0t)", tag, got, exp, e, $time);
    end
  endtask

  function automatic bit bs_at(input int i);
    return (i < 1) ? 1'b0 : bs[i];
  endfunction

  function automatic bit dl_at(input int i);
    return (i < 1) ? 1'b0 : dl[i];
  endfunction

  function automatic bit pr_at(input int i);
    return (i < 1) ? 1'b0 : pr[i];
  endfunction

  task automatic model_reset();
    e         = 0;
    last_flip = 0;
    run_start = 0;
    exp_en    = 1'b0;
    st        = MIdle;
  endtask

  task automatic model_edge();
    bit d, flip, press;
    // Accepted level: flips once the last N comparisons (the two-stage
    // synchroniser delays the button by two edges) all disagreed with it.
    if (N == 0) begin
      dl[e] = bs_at(e - 1);
    end else begin
      d    = dl_at(e - 1);
      flip = (e - last_flip >= N);
      for (int j = 0; j < N; j++) begin
        if (bs_at(e - 2 - j) == d) flip = 1'b0;
      end
      dl[e] = flip ? ~d : d;
      if (flip) last_flip = e;
    end
    pr[e] = dl_at(e - 1) & ~dl_at(e - 2);
    press = pr_at(e - 1);
    exp_en = 1'b0;
    case (st)
      MIdle: if (press) begin
        if (mode_s) begin
          st        = MRun;
          run_start = e;
        end else begin
          st     = MStep;
          exp_en = 1'b1;
        end
      end
      MStep: st = MIdle;
      MRun: begin
        if (press) st = MIdle;
        else exp_en = ((e - run_start) % Div == 0);
      end
      default: st = MIdle;
    endcase
  endtask

  task automatic step_cycle(input bit b, input bit m);
    @(negedge clk);
    btn_in = b;
    mode   = m;
    @(posedge clk);
    e++;
    if (e >= MaxE) begin
      $display("FAIL history_bound: edge %0d exceeds %0d", e, MaxE);
      $fatal(1);
    end
    bs[e]  = btn_in;
    mode_s = mode;
    #1;
    model_edge();
    check_bit("press_pulse", press_pulse, pr[e]);
    check_bit("Enable", Enable, exp_en);
    check_bit("running", running, st == MRun);
  endtask

  initial begin
    // Reset state
    #12;
    check_bit("rst_Enable", Enable, 1'b0);
    check_bit("rst_running", running, 1'b0);
    check_bit("rst_press_pulse", press_pulse, 1'b0);
    Reset = 1'b1;
    model_reset();

    // Step press
    repeat (20) step_cycle(1'b1, 1'b0);
    repeat (20) step_cycle(1'b0, 1'b0);

    // Bounce: toggle every 3 cycles
    for (int i = 0; i < 30; i++) step_cycle(((i / 3) % 2) == 0, 1'b0);
    repeat (20) step_cycle(1'b0, 1'b0);

    // Run mode with several ticks
    repeat (20) step_cycle(1'b1, 1'b1);
    repeat (30) step_cycle(1'b0, 1'b1);

    // Stop press timed to land on a tick; mode flips while running are ignored
    for (int i = 0; i < int'(Div); i++) begin
      if (((e + 1) + 3 + N - run_start) % Div == 0) break;
      step_cycle(1'b0, 1'b0);
    end
    repeat (20) step_cycle(1'b1, 1'b0);
    repeat (20) step_cycle(1'b0, 1'b1);

    // Reset mid-run, asserted and released between clock edges
    repeat (20) step_cycle(1'b1, 1'b1);
    repeat (10) step_cycle(1'b0, 1'b1);
    check_bit("pre_rst_running", running, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check_bit("async_rst_Enable", Enable, 1'b0);
    check_bit("async_rst_running", running, 1'b0);
    check_bit("async_rst_press_pulse", press_pulse, 1'b0);
    #2 Reset = 1'b1;
    model_reset();

    // Presses after reset: step then run/stop
    repeat (20) step_cycle(1'b1, 1'b0);
    repeat (20) step_cycle(1'b0, 1'b0);
    repeat (20) step_cycle(1'b1, 1'b1);
    repeat (25) step_cycle(1'b0, 1'b0);

    // Random segments of button level with per-cycle random mode
    for (int s = 0; s < 60; s++) begin
      int len;
      bit lvl;
      len = $urandom_range(1, 40);
      lvl = (s % 2) == 0;
      for (int k = 0; k < len; k++) step_cycle(lvl, 1'($urandom_range(0, 1)));
    end
    repeat (30) step_cycle(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
